c3lib_tie_bank_cfg: RTL and testbench
=====================================

// Module: c3lib_tie_bank_cfg
// PURPOSE
//  Parametrised, run-time programmable tie-off bank: WIDTH static control levels that come up
//  at a hardened reset value and can be re-programmed later through a four-phase handshake.
//  Each update waits a programmable settle window, then all bits change on the same clock edge.
//  An optional one-way lock freezes the bank until the next reset.
//  Drives static mode/strap inputs of AIB IO/adapter logic in place of fixed tie cells.
// PARAMETERS
//  WIDTH       8    number of tie outputs (>=1)
//  RST_VAL     '0   tie_out value during and after reset (WIDTH bits)
//  SETTLE_CYC  4    clk cycles between request acceptance and output update (0..255)
//  LOCK_EN     1    1: cfg_lock honoured; 0: cfg_lock ignored, locked stays 0
// PORTS
//  clk       in   1      block clock
//  rst       in   1      asynchronous, active-high reset
//  cfg_req   in   1      update request; held high until cfg_ack seen high
//  cfg_val   in   WIDTH  new tie values, sampled on the accepting edge only
//  cfg_mask  in   WIDTH  1 = take bit from cfg_val, 0 = keep current tie_out bit
//  cfg_lock  in   1      lock bank after this update (when LOCK_EN=1)
//  cfg_ack   out  1      handshake ack; high from apply edge until cfg_req low
//  cfg_err   out  1      valid with cfg_ack; 1 = request rejected (bank locked)
//  busy      out  1      high from accept edge until return to IDLE
//  locked    out  1      bank locked; sticky until rst
//  tie_out   out  WIDTH  registered tie levels
// BEHAVIOUR
//  - All outputs are registered, with no combinational paths from inputs.
//  - Reset (async assert, sync deassert by the integrator): tie_out=RST_VAL; cfg_ack, cfg_err,
//    busy and locked = 0; state=IDLE; counter=0.
//  - States IDLE, SETTLE, ACK.
//  - IDLE, cfg_req=1, locked=0 at edge N (accept):
//    - shadow <= (tie_out & ~cfg_mask) | (cfg_val & cfg_mask);
//    - lock_pend <= cfg_lock & LOCK_EN; cnt <= SETTLE_CYC; busy <= 1; go to SETTLE.
//  - IDLE, cfg_req=1, locked=1: cfg_ack <= 1, cfg_err <= 1, busy <= 1, go to ACK. tie_out is unchanged.
//  - SETTLE, cnt!=0: cnt <= cnt-1.
//  - SETTLE, cnt==0: tie_out <= shadow (all bits on one edge); cfg_ack <= 1; cfg_err <= 0;
//    locked <= locked | lock_pend; go to ACK.
//    - Update latency: tie_out and cfg_ack change at edge N+SETTLE_CYC+1.
//    - With SETTLE_CYC=0 the update lands at edge N+1.
//  - ACK: hold cfg_ack and cfg_err while cfg_req=1. When cfg_req=0: cfg_ack <= 0, cfg_err <= 0,
//    busy <= 0, go to IDLE. A new request is accepted no earlier than the edge after IDLE is re-entered.
//  - In SETTLE, changes on cfg_val, cfg_mask or cfg_lock are ignored; the shadow is frozen at accept.
//  - cfg_req dropping during SETTLE is a protocol violation. The update still completes, and
//    ACK exits on the first cycle with cfg_req=0. An SVA flags the violation.
//  - cfg_mask=0 in a request: tie_out is unchanged, but the full handshake still runs.
//  - rst asserted mid-update: the pending shadow is discarded; tie_out snaps to RST_VAL and locked clears.
//  - The counter width is $clog2(SETTLE_CYC+1), minimum 1. The counter never wraps because it reloads only on accept.
// STRUCTURE
//  - c3lib_tie_pkg holds:
//    - typedef enum logic [1:0] {TB_IDLE, TB_SETTLE, TB_ACK} tb_state_e;
//    - localparam TB_MAX_SETTLE = 255.
//  - One sub-module, c3lib_tie_bank_settle_cnt: loadable down-counter with a zero flag,
//    parameter SETTLE_CYC.
//  - The FSM, shadow register and tie_out register live in the top module.
//  - Elaboration checks: WIDTH>=1; SETTLE_CYC<=TB_MAX_SETTLE.
// TESTING
//  1. Reset with RST_VAL=8'hA5 -> tie_out=A5, cfg_ack=0, busy=0, locked=0 throughout reset and after release.
//  2. SETTLE_CYC=4, accept val=FF mask=0F at edge N, from tie_out=A5 -> tie_out=AF and cfg_ack=1 at N+5;
//     no change at N+1..N+4; cfg_ack falls and busy falls one edge after cfg_req=0.
//  3. Update with cfg_lock=1, then a second request val=00 mask=FF -> first applies and locked=1;
//     second gets cfg_ack=1, cfg_err=1, tie_out unchanged. With LOCK_EN=0, locked stays 0 and the second applies.
//  4. SETTLE_CYC=0 -> tie_out updates at N+1. cfg_val toggled every cycle during SETTLE -> output equals the
//     value sampled at accept.
//  5. Assert rst two cycles into SETTLE, with a lock pending -> tie_out=RST_VAL asynchronously,
//     locked=0, state IDLE. A fresh request after release completes normally.
//  6. Back-to-back: cfg_req re-raised on the cycle after ACK exit -> accepted one edge after IDLE entry,
//     with no lost or duplicated ack.

Source files
------------

// File: rtl/c3lib_tie_pkg.sv
// Shared types and limits for the programmable tie-off bank.
package c3lib_tie_pkg;

    typedef enum logic [1:0] {
        TB_IDLE   = 2'd0,
        TB_SETTLE = 2'd1,
        TB_ACK    = 2'd2
    } tb_state_e;

    localparam int TB_MAX_SETTLE = 255;

endpackage

// File: rtl/c3lib_tie_bank_cfg_chk.sv
// Protocol checker: the requester must keep cfg_req high while an update is settling.
module c3lib_tie_bank_cfg_chk (
    input logic clk,
    input logic rst,
    input logic in_settle,
    input logic cfg_req
);

    a_req_held_in_settle: assert property (
        @(posedge clk) disable iff (rst) in_settle |-> cfg_req
    ) else $error("cfg_req dropped while update was settling");

endmodule

// File: rtl/c3lib_tie_bank_settle_cnt.sv
// Loadable down-counter that times the settle window; zero flag comes straight from the register.
module c3lib_tie_bank_settle_cnt
    import c3lib_tie_pkg::*;
#(
    parameter int SETTLE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic cnt_zero
);

    localparam int CW = (SETTLE_CYC == 0) ? 1 : $clog2(SETTLE_CYC + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYC);

    logic [CW-1:0] cnt_r;

    // Reload on accept, otherwise count down and stop at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (load) begin
            cnt_r <= LOAD_VAL;
        end else if (dec && (cnt_r != {CW{1'b0}})) begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt_zero = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/c3lib_tie_bank_cfg.sv
// Run-time programmable tie-off bank: masked updates land on one edge after a settle window,
// with an optional sticky lock that rejects further updates until reset.
module c3lib_tie_bank_cfg
    import c3lib_tie_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RST_VAL    = '0,
    parameter int               SETTLE_CYC = 4,
    parameter int               LOCK_EN    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_req,
    input  logic [WIDTH-1:0] cfg_val,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic             cfg_lock,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic             busy,
    output logic             locked,
    output logic [WIDTH-1:0] tie_out
);

    if (WIDTH < 1) begin : g_bad_width
        $error("c3lib_tie_bank_cfg: WIDTH must be at least 1");
    end
    if (SETTLE_CYC > TB_MAX_SETTLE || SETTLE_CYC < 0) begin : g_bad_settle
        $error("c3lib_tie_bank_cfg: SETTLE_CYC out of range 0..255");
    end

    tb_state_e        state_r;
    logic [WIDTH-1:0] shadow_r;
    logic             lock_pend_r;
    logic             cnt_load_s;
    logic             cnt_dec_s;
    logic             cnt_zero_s;
    logic             lock_req_s;

    assign lock_req_s = (LOCK_EN != 0) ? cfg_lock : 1'b0;
    assign cnt_load_s = (state_r == TB_IDLE) && cfg_req && !locked;
    assign cnt_dec_s  = (state_r == TB_SETTLE) && !cnt_zero_s;

    c3lib_tie_bank_settle_cnt #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .dec      (cnt_dec_s),
        .cnt_zero (cnt_zero_s)
    );

    // Handshake FSM with shadow capture at accept and single-edge apply of all tie bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= TB_IDLE;
            shadow_r    <= RST_VAL;
            lock_pend_r <= 1'b0;
            tie_out     <= RST_VAL;
            cfg_ack     <= 1'b0;
            cfg_err     <= 1'b0;
            busy        <= 1'b0;
            locked      <= 1'b0;
        end else begin
            case (state_r)
                TB_IDLE: begin
                    if (cfg_req && locked) begin
                        cfg_ack <= 1'b1;
                        cfg_err <= 1'b1;
                        busy    <= 1'b1;
                        state_r <= TB_ACK;
                    end else if (cfg_req) begin
                        shadow_r    <= (tie_out & ~cfg_mask) | (cfg_val & cfg_mask);
                        lock_pend_r <= lock_req_s;
                        busy        <= 1'b1;
                        state_r     <= TB_SETTLE;
                    end else begin
                        state_r <= TB_IDLE;
                    end
                end
                TB_SETTLE: begin
                    if (cnt_zero_s) begin
                        tie_out <= shadow_r;
                        cfg_ack <= 1'b1;
                        cfg_err <= 1'b0;
                        locked  <= locked | lock_pend_r;
                        state_r <= TB_ACK;
                    end else begin
                        state_r <= TB_SETTLE;
                    end
                end
                TB_ACK: begin
                    if (!cfg_req) begin
                        cfg_ack <= 1'b0;
                        cfg_err <= 1'b0;
                        busy    <= 1'b0;
                        state_r <= TB_IDLE;
                    end else begin
                        state_r <= TB_ACK;
                    end
                end
                default: begin
                    state_r <= TB_IDLE;
                end
            endcase
        end
    end

    c3lib_tie_bank_cfg_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .in_settle (state_r == TB_SETTLE),
        .cfg_req   (cfg_req)
    );

endmodule

// File: tb/tb_c3lib_tie_bank_cfg.sv
// Directed bench for the tie bank: three instances cover settle=4 with lock, settle=0, and lock disabled.
module tb_c3lib_tie_bank_cfg;

    logic clk = 1'b0;
    logic rst;

    logic       req_a, lock_a, ack_a, err_a, busy_a, locked_a;
    logic [7:0] val_a, mask_a, tie_a;
    logic       req_b, lock_b, ack_b, err_b, busy_b, locked_b;
    logic [7:0] val_b, mask_b, tie_b;
    logic       req_c, lock_c, ack_c, err_c, busy_c, locked_c;
    logic [7:0] val_c, mask_c, tie_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    c3lib_tie_bank_cfg #(.WIDTH(8), .RST_VAL(8'hA5), .SETTLE_CYC(4), .LOCK_EN(1)) dut_a (
        .clk(clk), .rst(rst), .cfg_req(req_a), .cfg_val(val_a), .cfg_mask(mask_a),
        .cfg_lock(lock_a), .cfg_ack(ack_a), .cfg_err(err_a), .busy(busy_a),
        .locked(locked_a), .tie_out(tie_a));

    c3lib_tie_bank_cfg #(.WIDTH(8), .RST_VAL(8'h00), .SETTLE_CYC(0), .LOCK_EN(1)) dut_b (
        .clk(clk), .rst(rst), .cfg_req(req_b), .cfg_val(val_b), .cfg_mask(mask_b),
        .cfg_lock(lock_b), .cfg_ack(ack_b), .cfg_err(err_b), .busy(busy_b),
        .locked(locked_b), .tie_out(tie_b));

    c3lib_tie_bank_cfg #(.WIDTH(8), .RST_VAL(8'h00), .SETTLE_CYC(2), .LOCK_EN(0)) dut_c (
        .clk(clk), .rst(rst), .cfg_req(req_c), .cfg_val(val_c), .cfg_mask(mask_c),
        .cfg_lock(lock_c), .cfg_ack(ack_c), .cfg_err(err_c), .busy(busy_c),
        .locked(locked_c), .tie_out(tie_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it; inputs driven here are taken at the next edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req_a = 1'b0; lock_a = 1'b0; val_a = 8'h00; mask_a = 8'h00;
        req_b = 1'b0; lock_b = 1'b0; val_b = 8'h00; mask_b = 8'h00;
        req_c = 1'b0; lock_c = 1'b0; val_c = 8'h00; mask_c = 8'h00;

        // 1. reset values during and after reset
        #2;
        chk("rst_tie_async", {24'h0, tie_a}, 32'hA5);
        step(); step();
        chk("rst_tie", {24'h0, tie_a}, 32'hA5);
        chk("rst_ack", {31'h0, ack_a}, 32'h0);
        chk("rst_busy", {31'h0, busy_a}, 32'h0);
        chk("rst_locked", {31'h0, locked_a}, 32'h0);
        rst = 1'b0;
        step();
        chk("post_rst_tie", {24'h0, tie_a}, 32'hA5);
        chk("post_rst_busy", {31'h0, busy_a}, 32'h0);

        // 2. masked update, latency SETTLE_CYC+1
        req_a = 1'b1; val_a = 8'hFF; mask_a = 8'h0F;
        step();
        chk("acc_busy", {31'h0, busy_a}, 32'h1);
        chk("acc_tie", {24'h0, tie_a}, 32'hA5);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("settle_tie_%0d", k), {24'h0, tie_a}, 32'hA5);
            chk($sformatf("settle_ack_%0d", k), {31'h0, ack_a}, 32'h0);
        end
        step();
        chk("apply_tie", {24'h0, tie_a}, 32'hAF);
        chk("apply_ack", {31'h0, ack_a}, 32'h1);
        chk("apply_err", {31'h0, err_a}, 32'h0);
        step();
        chk("ack_hold", {31'h0, ack_a}, 32'h1);
        req_a = 1'b0;
        step();
        chk("ack_fall", {31'h0, ack_a}, 32'h0);
        chk("busy_fall", {31'h0, busy_a}, 32'h0);

        // 3. lock, then a rejected request
        req_a = 1'b1; val_a = 8'h3C; mask_a = 8'hFF; lock_a = 1'b1;
        for (int k = 0; k < 6; k++) step();
        chk("lock_tie", {24'h0, tie_a}, 32'h3C);
        chk("lock_locked", {31'h0, locked_a}, 32'h1);
        req_a = 1'b0; lock_a = 1'b0;
        step();
        req_a = 1'b1; val_a = 8'h00; mask_a = 8'hFF;
        step();
        chk("rej_ack", {31'h0, ack_a}, 32'h1);
        chk("rej_err", {31'h0, err_a}, 32'h1);
        chk("rej_busy", {31'h0, busy_a}, 32'h1);
        chk("rej_tie", {24'h0, tie_a}, 32'h3C);
        req_a = 1'b0;
        step();
        chk("rej_ack_fall", {31'h0, ack_a}, 32'h0);
        chk("rej_err_fall", {31'h0, err_a}, 32'h0);
        chk("rej_locked_sticky", {31'h0, locked_a}, 32'h1);

        // 3b. LOCK_EN=0: lock ignored, second update applies
        req_c = 1'b1; val_c = 8'h3C; mask_c = 8'hFF; lock_c = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("nolock_tie", {24'h0, tie_c}, 32'h3C);
        chk("nolock_locked", {31'h0, locked_c}, 32'h0);
        req_c = 1'b0; lock_c = 1'b0;
        step();
        req_c = 1'b1; val_c = 8'h00;
        for (int k = 0; k < 4; k++) step();
        chk("nolock_tie2", {24'h0, tie_c}, 32'h00);
        chk("nolock_err2", {31'h0, err_c}, 32'h0);
        req_c = 1'b0;
        step();

        // 4. SETTLE_CYC=0 lands at N+1; mask=0 leaves tie_out alone
        req_b = 1'b1; val_b = 8'h5A; mask_b = 8'hFF;
        step();
        chk("z_acc_tie", {24'h0, tie_b}, 32'h00);
        chk("z_acc_ack", {31'h0, ack_b}, 32'h0);
        step();
        chk("z_apply_tie", {24'h0, tie_b}, 32'h5A);
        chk("z_apply_ack", {31'h0, ack_b}, 32'h1);
        req_b = 1'b0;
        step();
        req_b = 1'b1; val_b = 8'hFF; mask_b = 8'h00;
        step(); step();
        chk("m0_ack", {31'h0, ack_b}, 32'h1);
        chk("m0_tie", {24'h0, tie_b}, 32'h5A);
        req_b = 1'b0;
        step();

        // 4b. cfg_val toggling during SETTLE is ignored
        req_c = 1'b1; val_c = 8'hF0; mask_c = 8'hFF;
        step();
        val_c = 8'h0F; step();
        val_c = 8'hAA; step();
        val_c = 8'h55; step();
        chk("frozen_tie", {24'h0, tie_c}, 32'hF0);
        chk("frozen_ack", {31'h0, ack_c}, 32'h1);
        req_c = 1'b0;
        step();

        // 5. reset two cycles into SETTLE with a lock pending (reset also clears dut_a's lock)
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        req_a = 1'b1; val_a = 8'h00; mask_a = 8'hFF; lock_a = 1'b1;
        step(); step(); step();
        rst = 1'b1; req_a = 1'b0; lock_a = 1'b0;
        #1;
        chk("mid_rst_tie", {24'h0, tie_a}, 32'hA5);
        chk("mid_rst_busy", {31'h0, busy_a}, 32'h0);
        chk("mid_rst_locked", {31'h0, locked_a}, 32'h0);
        step();
        rst = 1'b0;
        step();
        req_a = 1'b1; val_a = 8'h11; mask_a = 8'hFF;
        for (int k = 0; k < 6; k++) step();
        chk("fresh_tie", {24'h0, tie_a}, 32'h11);
        chk("fresh_ack", {31'h0, ack_a}, 32'h1);
        chk("fresh_locked", {31'h0, locked_a}, 32'h0);

        // 6. back-to-back: re-raise on the cycle after ACK exit
        req_a = 1'b0;
        step();
        chk("b2b_exit_ack", {31'h0, ack_a}, 32'h0);
        chk("b2b_exit_busy", {31'h0, busy_a}, 32'h0);
        req_a = 1'b1; val_a = 8'h22;
        step();
        chk("b2b_acc_busy", {31'h0, busy_a}, 32'h1);
        chk("b2b_acc_ack", {31'h0, ack_a}, 32'h0);
        for (int k = 0; k < 4; k++) step();
        chk("b2b_pre_ack", {31'h0, ack_a}, 32'h0);
        step();
        chk("b2b_tie", {24'h0, tie_a}, 32'h22);
        chk("b2b_ack", {31'h0, ack_a}, 32'h1);
        req_a = 1'b0;
        step();
        chk("b2b_ack_fall", {31'h0, ack_a}, 32'h0);
        step();
        chk("b2b_no_dup", {31'h0, busy_a}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
